even_odd_gen: RTL and testbench

EVEN_ODD_GEN -- requirements
Module: even_odd_gen

---
 rtl/even_odd_pkg.sv | 18 +
 rtl/parity_tag.sv | 16 +
 rtl/even_odd_gen.sv | 102 ++++++++++
 tb/tb_even_odd_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/even_odd_pkg.sv
// Shared constants for the even/odd sequence generator: parity codes,
// FSM state encodings and datapath widths.
package even_odd_pkg;

    // Parity codes presented on even_odd and expected on parity_sel
    localparam logic CODE_EVEN = 1'b1;
    localparam logic CODE_ODD  = 1'b0;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Emitted value width and remaining-count width (one extra bit of headroom)
    localparam int NUM_W = 4;
    localparam int CNT_W = 5;

endpackage

// File: rtl/parity_tag.sv
// Combinational parity classifier: maps a 4-bit value to the EVEN/ODD code.
// Shared by the seed-alignment path and the output tag.
module parity_tag
    import even_odd_pkg::*;
#(
    parameter logic EVEN = CODE_EVEN,
    parameter logic ODD  = CODE_ODD
) (
    input  logic [NUM_W-1:0] value,
    output logic             code
);

    // LSB clear means even
    assign code = value[0] ? ODD : EVEN;

endmodule

// File: rtl/even_odd_gen.sv
// Even/odd number sequence generator.
// On an accepted start, emits count_len values of the requested parity,
// beginning at start_value (or the next value up if its parity differs) and
// stepping by 2 modulo 16. Output uses a valid/ready handshake; a one-cycle
// done pulse marks the end of each sequence.
module even_odd_gen
    import even_odd_pkg::*;
#(
    parameter logic EVEN = CODE_EVEN,
    parameter logic ODD  = CODE_ODD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             parity_sel,
    input  logic [NUM_W-1:0] start_value,
    input  logic [NUM_W-1:0] count_len,
    input  logic             out_ready,
    output logic [NUM_W-1:0] number,
    output logic             out_valid,
    output logic             even_odd,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state;
    logic [CNT_W-1:0] remaining;
    logic             seed_code;
    logic [NUM_W-1:0] first_value;
    logic             xfer;

    // Classify the seed so it can be bumped onto the requested parity
    parity_tag #(
        .EVEN (EVEN),
        .ODD  (ODD)
    ) u_seed_tag (
        .value (start_value),
        .code  (seed_code)
    );

    // Tag the value currently presented; stays consistent with number
    // including the reset value of 0
    parity_tag #(
        .EVEN (EVEN),
        .ODD  (ODD)
    ) u_out_tag (
        .value (number),
        .code  (even_odd)
    );

    // 15 + 1 wraps to 0, which keeps the even request satisfied
    assign first_value = (seed_code == parity_sel) ? start_value
                                                   : start_value + 4'd1;
    assign xfer        = out_valid & out_ready;
    assign busy        = (state != ST_IDLE);
    // DONE lasts exactly one cycle, so the pulse falls out of the state
    assign done        = (state == ST_DONE);

    // Sequence controller and output register; inputs are only looked at in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            number    <= '0;
            out_valid <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= {1'b0, count_len};
                        if (count_len != 4'd0) begin
                            number    <= first_value;
                            out_valid <= 1'b1;
                            state     <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        remaining <= remaining - 5'd1;
                        if (remaining == 5'd1) begin
                            // Last value accepted: drop valid and hold number
                            out_valid <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            number <= number + 4'd2;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_even_odd_gen.sv
// Scoreboard bench for even_odd_gen: the stimulus side predicts each
// sequence arithmetically and queues it; the monitor checks every presented
// value and the done pulse against that queue.
`timescale 1ns/1ps
module tb_even_odd_gen;

    localparam logic TB_EVEN = 1'b1;
    localparam logic TB_ODD  = 1'b0;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       parity_sel;
    logic [3:0] start_value;
    logic [3:0] count_len;
    logic       out_ready;
    logic [3:0] number;
    logic       out_valid;
    logic       even_odd;
    logic       busy;
    logic       done;

    typedef struct {
        logic [3:0] num;
        logic       code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors      = 0;
    int   miscompares  = 0;
    int   done_pending = 0;
    int   transfers    = 0;

    even_odd_gen #(
        .EVEN (TB_EVEN),
        .ODD  (TB_ODD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .parity_sel  (parity_sel),
        .start_value (start_value),
        .count_len   (count_len),
        .out_ready   (out_ready),
        .number      (number),
        .out_valid   (out_valid),
        .even_odd    (even_odd),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Inputs change just after the rising edge; outputs are read mid-low-phase
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    function automatic logic pick_ready(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        return (k >= 3);
    endfunction

    task automatic scramble();
        start       = 1'($urandom_range(0, 1));
        parity_sel  = 1'($urandom_range(0, 1));
        start_value = 4'($urandom_range(0, 15));
        count_len   = 4'($urandom_range(0, 15));
    endtask

    // Reference: first value of the requested parity at or just above the
    // seed, then steps of two, all modulo 16
    task automatic predict(input logic par, input logic [3:0] sv, input logic [3:0] len);
        int f;
        int v;
        f = ((int'(sv) % 2 == 0) == (par == TB_EVEN)) ? int'(sv) : (int'(sv) + 1) % 16;
        for (int i = 0; i < int'(len); i++) begin
            v = (f + 2 * i) % 16;
            exp_q.push_back('{num: 4'(v), code: ((v % 2) == 0) ? TB_EVEN : TB_ODD});
        end
        done_pending++;
    endtask

    // Monitor: every presented value must match the head of the queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(out_valid), 32'(1'b0));
            end else if (out_valid) begin
                chk("number", 32'(number), 32'(exp_q[0].num));
                chk("even_odd", 32'(even_odd), 32'(exp_q[0].code));
                if (out_ready) begin
                    mon_e = exp_q.pop_front();
                    transfers++;
                end
            end
            if (done && done_pending == 0) begin
                chk("unexpected_done", 32'(done), 32'(1'b0));
            end else if (done) begin
                chk("done_before_all_values", 32'(exp_q.size()), 32'(0));
                done_pending--;
            end
        end
    end

    task automatic run_seq(input logic par, input logic [3:0] sv, input logic [3:0] len,
                           input int mode, input bit garbage);
        int cyc;
        int base;
        cyc = 0;
        while (busy && cyc < 100) begin
            step();
            cyc++;
        end
        chk("idle_before_start", 32'(busy), 32'(1'b0));
        base        = transfers;
        start       = 1'b1;
        parity_sel  = par;
        start_value = sv;
        count_len   = len;
        out_ready   = pick_ready(mode, 0);
        predict(par, sv, len);
        step();
        start = 1'b0;
        if (garbage) scramble();
        sample();
        chk("valid_latency", 32'(out_valid), 32'(len != 4'd0));
        chk("busy_after_start", 32'(busy), 32'(1'b1));
        chk("done_zero_len", 32'(done), 32'(len == 4'd0));
        cyc = 1;
        while (done_pending > 0 && cyc < 300) begin
            step();
            out_ready = pick_ready(mode, cyc);
            if (garbage) scramble();
            sample();
            cyc++;
        end
        chk("done_timeout", 32'(done_pending), 32'(0));
        if (done_pending != 0) begin
            exp_q.delete();
            done_pending = 0;
        end
        chk("transfer_count", 32'(transfers - base), 32'(len));
        if (mode == 0) chk("back_to_back_cycles", 32'(cyc), 32'(int'(len) + 1));
        // Start held high across DONE->IDLE must not launch a new run
        if (garbage) start = 1'b1;
        step();
        start = 1'b0;
        sample();
        chk("idle_after_done", 32'(busy), 32'(1'b0));
        chk("done_one_cycle", 32'(done), 32'(1'b0));
        step();
        sample();
        chk("no_restart", 32'(busy), 32'(1'b0));
    endtask

    task automatic reset_mid_run();
        int base;
        int cyc;
        base        = transfers;
        start       = 1'b1;
        parity_sel  = TB_ODD;
        start_value = 4'($urandom_range(0, 15));
        count_len   = 4'd6;
        out_ready   = 1'b1;
        predict(parity_sel, start_value, count_len);
        step();
        start = 1'b0;
        cyc = 0;
        while (transfers - base < 2 && cyc < 50) begin
            sample();
            cyc++;
        end
        step();
        chk("transfers_before_reset", 32'(transfers - base), 32'(2));
        rst_n = 1'b0;
        exp_q.delete();
        done_pending = 0;
        #1;
        chk("rst_number", 32'(number), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_even_odd", 32'(even_odd), 32'(TB_EVEN));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_done", 32'(done), 32'(1'b0));
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("post_rst_busy", 32'(busy), 32'(1'b0));
            chk("post_rst_valid", 32'(out_valid), 32'(1'b0));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        parity_sel  = TB_EVEN;
        start_value = 4'd0;
        count_len   = 4'd0;
        out_ready   = 1'b0;
        #3;
        chk("reset_number", 32'(number), 32'(0));
        chk("reset_out_valid", 32'(out_valid), 32'(1'b0));
        chk("reset_even_odd", 32'(even_odd), 32'(TB_EVEN));
        chk("reset_busy", 32'(busy), 32'(1'b0));
        chk("reset_done", 32'(done), 32'(1'b0));
        step();
        step();
        rst_n = 1'b1;
        sample();
        chk("idle_after_reset", 32'(busy), 32'(1'b0));

        run_seq(TB_EVEN, 4'd3, 4'd4, 0, 1'b0);    // 4,6,8,10
        run_seq(TB_ODD, 4'd12, 4'd3, 0, 1'b0);    // 13,15,1
        run_seq(TB_EVEN, 4'd15, 4'd2, 2, 1'b0);   // 0 held, then 0,2
        run_seq(TB_EVEN, 4'd5, 4'd0, 0, 1'b1);    // empty sequence
        reset_mid_run();
        run_seq(TB_ODD, 4'd6, 4'd6, 0, 1'b0);     // normal run after reset
        run_seq(TB_EVEN, 4'd7, 4'd5, 0, 1'b1);    // inputs churn during run
        run_seq(TB_ODD, 4'd14, 4'd15, 1, 1'b1);   // longest run, wraps

        for (int i = 0; i < 30; i++) begin
            run_seq(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
